spi_slave_cfg: RTL

//  Parametrised SPI slave, successor of the fixed-format slave. Oversamples SCLK/CS/MOSI in the sysclk

---
 rtl/spi_slave_cfg_pkg.sv | 20 ++
 rtl/spi_slave_cfg_sync_edge.sv | 25 ++
 rtl/spi_slave_cfg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/spi_slave_cfg_pkg.sv
// Shared defaults, FSM state encoding and SCLK edge helper for the configurable SPI slave.
package spi_slave_cfg_pkg;

  localparam int unsigned CMD_BITS_DEF     = 8;
  localparam int unsigned ADDR_BITS_DEF    = 8;
  localparam int unsigned PAYLOAD_BITS_DEF = 8;
  localparam int unsigned SYNC_STAGES_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_WAIT_CS = 2'd2
  } state_e;

  // The leading edge is the one that moves SCLK away from its CPOL idle level.
  function automatic logic is_leading(input logic lvl_after, input logic cpol);
    return lvl_after != cpol;
  endfunction

endpackage

// File: rtl/spi_slave_cfg_sync_edge.sv
// N-stage synchroniser with one extra delay flop; rise/fall pulses last one sysclk cycle.
module spi_slave_cfg_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain and edge-detect delay; left unreset so it tracks the pin through reset.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[STAGES-2:0], d_i};
    prev_q <= sync_q[STAGES-1];
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_cfg.sv
// Oversampling SPI slave, all four CPOL/CPHA modes, configurable cmd/addr/payload field widths.
module spi_slave_cfg
  import spi_slave_cfg_pkg::*;
#(
  parameter int unsigned CMD_BITS     = CMD_BITS_DEF,
  parameter int unsigned ADDR_BITS    = ADDR_BITS_DEF,
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter bit          CPOL         = 1'b0,
  parameter bit          CPHA         = 1'b0,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic                                       sysclk,
  input  logic                                       rst,
  input  logic                                       sclk,
  input  logic                                       cs,
  input  logic                                       mosi,
  output logic                                       miso,
  input  logic                                       slv_tx_enb,
  input  logic [CMD_BITS+ADDR_BITS+PAYLOAD_BITS-1:0] i_slv_frame,
  output logic [CMD_BITS-1:0]                        o_cmd,
  output logic [ADDR_BITS-1:0]                       o_addr,
  output logic [PAYLOAD_BITS-1:0]                    o_payload,
  output logic                                       o_frame_valid,
  output logic                                       o_frame_err,
  output logic                                       o_busy
);

  localparam int unsigned      FRAME_W  = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
  localparam int unsigned      CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                    sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic                    cs_lvl_s, cs_rise_s, cs_fall_s;
  logic [SYNC_STAGES-1:0]  mosi_sync_q;
  logic                    mosi_s, sclk_edge_s, lead_s, trail_s, sample_s, shift_s;
  state_e                  state_q, state_d;
  logic [FRAME_W-1:0]      tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_next_s;
  logic [CNT_W-1:0]        rx_cnt_q, rx_cnt_d;
  logic                    miso_q, miso_d;
  logic [CMD_BITS-1:0]     cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic                    valid_q, valid_d, err_q, err_d;

  spi_slave_cfg_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i  (sysclk),
    .d_i    (sclk),
    .level_o(sclk_lvl_s),
    .rise_o (sclk_rise_s),
    .fall_o (sclk_fall_s)
  );

  spi_slave_cfg_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk_i  (sysclk),
    .d_i    (cs),
    .level_o(cs_lvl_s),
    .rise_o (cs_rise_s),
    .fall_o (cs_fall_s)
  );

  // MOSI synchroniser; same depth as SCLK so data and edge line up in the detect cycle.
  always_ff @(posedge sysclk) begin
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_edge_s = sclk_rise_s | sclk_fall_s;
  assign lead_s      = sclk_edge_s & is_leading(sclk_lvl_s, CPOL);
  assign trail_s     = sclk_edge_s & ~is_leading(sclk_lvl_s, CPOL);
  assign sample_s    = CPHA ? trail_s : lead_s;
  assign shift_s     = CPHA ? lead_s : trail_s;
  assign rx_next_s   = {rx_sr_q[FRAME_W-2:0], mosi_s};

  // Frame FSM next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_cnt_d  = rx_cnt_q;
    miso_d    = miso_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    payload_d = payload_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          tx_sr_d  = slv_tx_enb ? i_slv_frame : '0;
          rx_cnt_d = '0;
          miso_d   = 1'b0;
          state_d  = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (shift_s) begin
          miso_d  = tx_sr_q[FRAME_W-1];
          tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
        end else begin
          tx_sr_d = tx_sr_q;
        end
        // A final sample edge wins over a cs release detected in the same cycle.
        if (sample_s && (rx_cnt_q == CNT_LAST)) begin
          rx_sr_d   = rx_next_s;
          rx_cnt_d  = rx_cnt_q + CNT_ONE;
          cmd_d     = rx_next_s[FRAME_W-1 -: CMD_BITS];
          addr_d    = rx_next_s[PAYLOAD_BITS +: ADDR_BITS];
          payload_d = rx_next_s[PAYLOAD_BITS-1:0];
          valid_d   = 1'b1;
          state_d   = cs_rise_s ? ST_IDLE : ST_WAIT_CS;
        end else if (cs_rise_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sample_s) begin
          rx_sr_d  = rx_next_s;
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_WAIT_CS: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_CS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; a frame in flight at reset is dropped by parking in WAIT_CS.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= cs_lvl_s ? ST_IDLE : ST_WAIT_CS;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_cnt_q  <= '0;
      miso_q    <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_cnt_q  <= rx_cnt_d;
      miso_q    <= miso_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign miso          = (state_q == ST_ACTIVE) & (CPHA ? miso_q : tx_sr_q[FRAME_W-1]);
  assign o_cmd         = cmd_q;
  assign o_addr        = addr_q;
  assign o_payload     = payload_q;
  assign o_frame_valid = valid_q;
  assign o_frame_err   = err_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule
